// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: byte-serial unsigned magnitude compare of two NBYTES-wide operands through one cmp8
module seq_mag_cmp #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic                  EQ,
  output logic                  GT,
  output logic                  LT
);
  localparam int IW = $clog2(NBYTES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [8*NBYTES-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic [7:0] a_byte, b_byte;
  logic eq_acc, gt_acc, c_eq, c_gt, last, load;
  assign a_byte = a_q[8*idx +: 8];
  assign b_byte = b_q[8*idx +: 8];
  assign last = idx == IW'(NBYTES - 1);
  // a new request may be taken from IDLE or straight out of the result cycle
  assign load = start && state != RUN;
  cmp8 u_cmp (
    .a  (a_byte),
    .b  (b_byte),
    .eq (eq_acc),
    .gt (gt_acc),
    .EQ (c_eq),
    .GT (c_gt)
  );
  always_comb begin
    state_nx = state;
    busy = state == RUN;
    done = state == FIN;
    state_nx = state == RUN ? (last ? FIN : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
      EQ     <= 1'b0;
      GT     <= 1'b0;
      LT     <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        a_q    <= a;
        b_q    <= b;
        idx    <= '0;
        eq_acc <= 1'b1;
        gt_acc <= 1'b0;
      end else if (state == RUN) begin
        eq_acc <= c_eq;
        gt_acc <= c_gt;
        idx    <= idx + 1'b1;
        if (last) begin
          EQ <= c_eq;
          GT <= c_gt;
          LT <= !c_eq && !c_gt;
        end
      end
    end
  end
endmodule

// cmp8: combinational 8-bit magnitude compare, index 0 is the byte MSB; eq/gt cascade from the less significant byte
module cmp8 (
  input  logic [0:7] a,
  input  logic [0:7] b,
  input  logic       eq,
  input  logic       gt,
  output logic       EQ,
  output logic       GT
);
  assign EQ = (a == b) && eq;
  assign GT = (a > b) || ((a == b) && gt);
endmodule

// File: tb/tb_seq_mag_cmp.sv
// tb_seq_mag_cmp: directed checks of seq_mag_cmp at NBYTES=4 and NBYTES=1
module tb_seq_mag_cmp;
  logic clk = 0, rst = 1;
  logic start = 0, start1 = 0;
  logic [31:0] a = 0, b = 0;
  logic [7:0] a1 = 0, b1 = 0;
  logic busy, done, EQ, GT, LT;
  logic busy1, done1, EQ1, GT1, LT1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  seq_mag_cmp #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .EQ(EQ), .GT(GT), .LT(LT)
  );
  seq_mag_cmp #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .EQ(EQ1), .GT(GT1), .LT(LT1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) c++;
    end
  endtask

  // {EQ,GT,LT} expected as 3'b100 / 3'b010 / 3'b001
  task automatic do_cmp(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic [2:0] exp);
    logic [2:0] prev;
    int n;
    prev = {EQ, GT, LT};
    a = av; b = bv; start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_hold"}, {EQ, GT, LT}, prev);
    wait_done(n);
    chk({tag, "_lat"}, n + 1, 5);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_res"}, {EQ, GT, LT}, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int n, c;
    @(negedge clk);
    chk("rst_out", {busy, done, EQ, GT, LT}, 0);
    chk("rst_out1", {busy1, done1, EQ1, GT1, LT1}, 0);
    rst = 0;
    @(negedge clk);
    do_cmp("eq", 32'h12345678, 32'h12345678, 3'b100);
    do_cmp("msb", 32'h80000000, 32'h7FFFFFFF, 3'b010);
    do_cmp("gt_low", 32'h00000002, 32'h00000001, 3'b010);
    // operand changes and a start pulse during RUN must be ignored
    a = 32'h000000FF; b = 32'h00000100; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h0; start = 1;
    @(negedge clk);
    start = 0;
    chk("ign_busy", busy, 1);
    wait_done(n);
    chk("ign_lat", n + 3, 5);
    chk("ign_res", {EQ, GT, LT}, 3'b001);
    count_done(8, c);
    chk("ign_nodone", c, 0);
    chk("ign_hold", {EQ, GT, LT}, 3'b001);
    // continuous start: one result every 5 cycles
    a = 32'd5; b = 32'd9; start = 1;
    @(negedge clk);
    wait_done(n);
    chk("b2b_first", n + 1, 5);
    chk("b2b_res0", {EQ, GT, LT}, 3'b001);
    @(negedge clk);
    wait_done(n);
    chk("b2b_gap1", n + 1, 5);
    chk("b2b_res1", {EQ, GT, LT}, 3'b001);
    a = 32'd9;
    @(negedge clk);
    chk("b2b_rerun", busy, 1);
    wait_done(n);
    chk("b2b_gap2", n + 1, 5);
    chk("b2b_res2", {EQ, GT, LT}, 3'b100);
    start = 0;
    @(negedge clk);
    chk("b2b_idle", {busy, done}, 0);
    // abort in the second RUN cycle
    a = 32'd1; b = 32'd2; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    chk("abort_prev", {EQ, GT, LT}, 3'b100);
    rst = 1;
    #1;
    chk("abort_out", {busy, done, EQ, GT, LT}, 0);
    @(negedge clk);
    rst = 0;
    count_done(8, c);
    chk("abort_nodone", c, 0);
    chk("abort_idle", {busy, EQ, GT, LT}, 0);
    do_cmp("fresh", 32'h00000010, 32'h00000001, 3'b010);
    do_cmp("lt_mid", 32'h00FF0000, 32'h01000000, 3'b001);
    // single-byte instance
    a1 = 8'hA5; b1 = 8'h5A; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("n1_busy", {busy1, done1}, 2'b10);
    @(negedge clk);
    chk("n1_done", {busy1, done1}, 2'b01);
    chk("n1_gt", {EQ1, GT1, LT1}, 3'b010);
    @(negedge clk);
    chk("n1_idle", {busy1, done1}, 0);
    a1 = 8'h10; b1 = 8'h20; start1 = 1;
    @(negedge clk);
    start1 = 0;
    @(negedge clk);
    chk("n1_lt", {done1, EQ1, GT1, LT1}, 4'b1001);
    a1 = 8'h77; b1 = 8'h77; start1 = 1;
    @(negedge clk);
    start1 = 0;
    @(negedge clk);
    chk("n1_eq", {done1, EQ1, GT1, LT1}, 4'b1100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
